// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the transmit sequencer.
// The state set depends on the TX_PARITY_EN macro (adds the parity state).
package tx_seq_pkg;

    // Largest burst depth the sequencer is built for.
    localparam int unsigned MAX_DEPTH = 256;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRead   = 3'd1,
        StLoad   = 3'd2,
        StShift  = 3'd3,
`ifdef TX_PARITY_EN
        StParity = 3'd4,
`endif
        StInc    = 3'd5,
        StFinish = 3'd6
    } tx_seq_state_e;

    // Effective burst length: 0 or anything past the depth means a full-depth burst.
    function automatic int unsigned clamp_len(int unsigned len, int unsigned depth);
        int unsigned lim;
        begin
            lim = (depth > MAX_DEPTH) ? MAX_DEPTH : depth;
            if (len == 0 || len > lim) begin
                return lim;
            end
            return len;
        end
    endfunction

endpackage

// File: rtl/tx_seq_ctrl_if.sv
// Handshake and strobe bundle between the sequencer and its datapath.
// par_sel exists only when TX_PARITY_EN is defined.
interface tx_seq_ctrl_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              rx_ready;
    logic              abort;
    logic [ADDR_W:0]   burst_len;
    logic              read;
    logic              load;
    logic              shift;
`ifdef TX_PARITY_EN
    logic              par_sel;
`endif
    logic              inc;
    logic              tx_valid;
    logic              tx_finish;
    logic              busy;
    logic [ADDR_W-1:0] addr;

    // Sequencer side.
    modport master (
`ifdef TX_PARITY_EN
        output par_sel,
`endif
        input  rx_ready, abort, burst_len,
        output read, load, shift, inc, tx_valid, tx_finish, busy, addr
    );

    // Datapath / environment side.
    modport slave (
`ifdef TX_PARITY_EN
        input  par_sel,
`endif
        output rx_ready, abort, burst_len,
        input  read, load, shift, inc, tx_valid, tx_finish, busy, addr
    );

endinterface

// File: rtl/tx_bit_cnt.sv
// Bit-within-word counter: synchronous clear wins over enable; tc flags the last bit.
module tx_bit_cnt #(
    parameter int unsigned       CNT_W  = 3,
    parameter logic [CNT_W-1:0]  TC_VAL = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, otherwise count up on enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/tx_seq_ctrl.sv
// Transmit sequencer: per word issues read, load, DATA_W shifts (stalling on
// rx_ready low), optional parity, then an address increment; finishes after the
// latched burst length. Optional feature macro: TX_PARITY_EN.
module tx_seq_ctrl
    import tx_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    tx_seq_ctrl_if.master bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    tx_seq_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  len_eff;
    logic              cnt_clr, cnt_en, cnt_tc;

    assign len_eff = LEN_W'(clamp_len(32'(bus.burst_len), DEPTH));

    tx_bit_cnt #(
        .CNT_W  (CNT_W),
        .TC_VAL (CNT_W'(DATA_W - 1))
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // Next state, address/length updates and state-decoded strobes.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        bus.read      = 1'b0;
        bus.load      = 1'b0;
        bus.shift     = 1'b0;
        bus.inc       = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_finish = 1'b0;
`ifdef TX_PARITY_EN
        bus.par_sel   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (bus.rx_ready) begin
                    state_d = StRead;
                    // Only a fresh burst (address back at 0) picks up a new length.
                    if (addr_q == '0) begin
                        len_d = len_eff;
                    end
                end
            end
            StRead: begin
                bus.read = 1'b1;
                state_d  = StLoad;
            end
            StLoad: begin
                bus.load = 1'b1;
                cnt_clr  = 1'b1;
                state_d  = StShift;
            end
            StShift: begin
                if (bus.rx_ready) begin
                    bus.shift    = 1'b1;
                    bus.tx_valid = 1'b1;
                    cnt_en       = 1'b1;
                    if (cnt_tc) begin
`ifdef TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StInc;
`endif
                    end
                end
            end
`ifdef TX_PARITY_EN
            StParity: begin
                bus.tx_valid = 1'b1;
                bus.par_sel  = 1'b1;
                state_d      = StInc;
            end
`endif
            StInc: begin
                bus.inc      = 1'b1;
                bus.tx_valid = 1'b1;
                if ({1'b0, addr_q} == len_q - 1'b1) begin
                    // Address is cleared on entry to FINISH rather than incremented.
                    addr_d  = '0;
                    state_d = StFinish;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = bus.rx_ready ? StRead : StIdle;
                end
            end
            StFinish: begin
                bus.tx_finish = 1'b1;
                if (!bus.rx_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides every transition, including INC -> FINISH.
        if (bus.abort) begin
            state_d = StIdle;
            addr_d  = '0;
            cnt_clr = 1'b1;
        end
    end

    // State, address and latched-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.addr = addr_q;

endmodule
